// File: rtl/signed_divider_pkg.sv
// Shared widths, FSM state encoding and saturation values for the signed divider.
package sdiv_pkg;
   localparam int DVD_W = 32;
   localparam int DVS_W = 16;
   localparam int CNT_W = 5;

   localparam logic [DVS_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [DVS_W-1:0] SAT_NEG = 16'h8000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      ITER  = 3'd2,
      FIX   = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/signed_divider_step.sv
// One restoring shift-subtract step on unsigned magnitudes; purely combinational.
module sdiv_step
   import sdiv_pkg::*;
(
   input  logic [DVS_W-1:0] part_rem,
   input  logic             bit_in,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W-1:0] next_rem,
   output logic             q_bit
);
   logic [DVS_W:0]   trial;
   logic [DVS_W-1:0] diff;

   assign trial = {part_rem, bit_in};
   // part_rem < divisor on entry, so the true difference always fits in DVS_W bits
   assign diff     = trial[DVS_W-1:0] - divisor;
   assign q_bit    = (trial >= {1'b0, divisor});
   assign next_rem = q_bit ? diff : trial[DVS_W-1:0];
endmodule

// File: rtl/signed_divider.sv
// 32/16 signed divider, truncating; remainder port only with SIGNED_DIVIDER_REM_EN.
// Latency: result 18 edges after accept, 2 edges for divide-by-zero or early overflow.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module signed_divider
   import sdiv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DVS_W-1:0] quotient,
`ifdef SIGNED_DIVIDER_REM_EN
   output logic [DVS_W-1:0] remainder,
`endif
   output logic             div_by_zero,
   output logic             overflow,
   output logic             busy
);
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [DVS_W-1:0] part_rem;
   logic [DVS_W-1:0] low;
   logic [DVS_W-1:0] dvs_mag;
   logic             sign_dvd;
   logic             sign_dvs;
   logic [DVS_W-1:0] quot_q;
   logic             dbz_q;
   logic             ovf_q;

   // SETUP works in place: part_rem/low/dvs_mag still hold the raw operands
   logic [DVD_W-1:0] dvd_raw;
   logic [DVD_W-1:0] dvd_mag;
   logic [DVS_W-1:0] dvs_mag_n;
   logic             dvd_neg;
   logic             dvs_neg;

   assign dvd_raw   = {part_rem, low};
   assign dvd_neg   = part_rem[DVS_W-1];
   assign dvs_neg   = dvs_mag[DVS_W-1];
   assign dvd_mag   = dvd_neg ? (32'd0 - dvd_raw) : dvd_raw;
   assign dvs_mag_n = dvs_neg ? (16'd0 - dvs_mag) : dvs_mag;

   logic [DVS_W-1:0] step_rem;
   logic             step_q;

   sdiv_step u_step (
      .part_rem (part_rem),
      .bit_in   (low[DVS_W-1]),
      .divisor  (dvs_mag),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   logic             q_neg;
   logic             fix_ovf;
   logic [DVS_W-1:0] q_signed;
   logic             early;

   assign q_neg    = sign_dvd ^ sign_dvs;
   assign fix_ovf  = q_neg ? (low > SAT_NEG) : (low > SAT_POS);
   assign q_signed = q_neg ? (16'd0 - low) : low;
   assign early    = dbz_q | ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         part_rem <= '0;
         low      <= '0;
         dvs_mag  <= '0;
         sign_dvd <= 1'b0;
         sign_dvs <= 1'b0;
         quot_q   <= '0;
         dbz_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  part_rem <= dividend[DVD_W-1:DVS_W];
                  low      <= dividend[DVS_W-1:0];
                  dvs_mag  <= divisor;
                  dbz_q    <= 1'b0;
                  ovf_q    <= 1'b0;
                  cnt      <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               sign_dvd <= dvd_neg;
               sign_dvs <= dvs_neg;
               part_rem <= dvd_mag[DVD_W-1:DVS_W];
               low      <= dvd_mag[DVS_W-1:0];
               dvs_mag  <= dvs_mag_n;
               // Early exits still pass through FIX so their timing is fixed at two edges
               if (dvs_mag == '0) begin
                  dbz_q  <= 1'b1;
                  quot_q <= dvd_neg ? SAT_NEG : SAT_POS;
                  state  <= FIX;
               end else if (dvd_mag[DVD_W-1:DVS_W] >= dvs_mag_n) begin
                  ovf_q  <= 1'b1;
                  quot_q <= (dvd_neg == dvs_neg) ? SAT_POS : SAT_NEG;
                  state  <= FIX;
               end else begin
                  state  <= ITER;
               end
            end
            ITER: begin
               part_rem <= step_rem;
               low      <= {low[DVS_W-2:0], step_q};
               cnt      <= cnt + 5'd1;
               if (cnt == 5'd15)
                  state <= FIX;
            end
            FIX: begin
               if (!early) begin
                  if (fix_ovf) begin
                     ovf_q  <= 1'b1;
                     quot_q <= q_neg ? SAT_NEG : SAT_POS;
                  end else begin
                     quot_q <= q_signed;
                  end
               end
               state <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SIGNED_DIVIDER_REM_EN
   logic [DVS_W-1:0] rem_q;
   logic [DVS_W-1:0] rem_signed;

   assign rem_signed = sign_dvd ? (16'd0 - part_rem) : part_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rem_q <= '0;
      else if (state == SETUP)
         rem_q <= (dvs_mag == '0) ? low : '0;
      else if (state == FIX && !early)
         rem_q <= fix_ovf ? '0 : rem_signed;
   end

   assign remainder = rem_q;
`endif

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign quotient    = quot_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider: vector table plus backpressure and mid-run reset sequences.
module tb_signed_divider;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;
   logic        busy;

   int tests = 0;
   int fails = 0;

   signed_divider dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
`ifdef SIGNED_DIVIDER_REM_EN
      .remainder   (remainder),
`endif
      .div_by_zero (div_by_zero),
      .overflow    (overflow),
      .busy        (busy)
   );

`ifndef SIGNED_DIVIDER_REM_EN
   assign remainder = 16'h0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] dvd;
      logic [15:0] dvs;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents operands in the current cycle; returns just after the accept edge.
   task automatic start_op(input string name, input logic [31:0] dvd, input logic [15:0] dvs);
      check({name, " in_ready before accept"}, in_ready, 1);
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({name, " busy after accept"}, busy, 1);
      check({name, " in_ready after accept"}, in_ready, 0);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic check_result(input string name, input logic [15:0] q, input logic [15:0] r,
                               input logic dbz, input logic ovf);
      check({name, " out_valid"}, out_valid, 1);
      check({name, " quotient"}, quotient, q);
      check({name, " div_by_zero"}, div_by_zero, dbz);
      check({name, " overflow"}, overflow, ovf);
`ifdef SIGNED_DIVIDER_REM_EN
      check({name, " remainder"}, remainder, r);
`endif
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string name, input vec_t v);
      int n;
      start_op(name, v.dvd, v.dvs);
      wait_valid(n);
      check({name, " latency"}, n, v.lat);
      check_result(name, v.q, v.r, v.dbz, v.ovf);
      handshake();
   endtask

   initial begin
      int n;
      vecs[0]  = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 18};
      vecs[1]  = '{32'hFFFF_FF9C, 16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0, 18};
      vecs[2]  = '{32'd100,       16'hFFF9,   16'hFFF2,   16'h0002,   1'b0, 1'b0, 18};
      vecs[3]  = '{32'hFFFF_FF9C, 16'hFFF9,   16'd14,     16'hFFFE,   1'b0, 1'b0, 18};
      vecs[4]  = '{32'h8000_0000, 16'hFFFF,   16'h7FFF,   16'h0000,   1'b0, 1'b1, 2};
      vecs[5]  = '{32'h3FFF_8000, 16'h7FFF,   16'h7FFF,   16'h0000,   1'b0, 1'b1, 18};
      vecs[6]  = '{32'hC000_8000, 16'h7FFF,   16'h8000,   16'h0000,   1'b0, 1'b0, 18};
      vecs[7]  = '{32'd1234,      16'd0,      16'h7FFF,   16'h04D2,   1'b1, 1'b0, 2};
      vecs[8]  = '{32'hFFFF_FFFB, 16'd0,      16'h8000,   16'hFFFB,   1'b1, 1'b0, 2};
      vecs[9]  = '{32'd0,         16'd5,      16'h0000,   16'h0000,   1'b0, 1'b0, 18};
      vecs[10] = '{32'h7FFF_FFFF, 16'h7FFF,   16'h7FFF,   16'h0000,   1'b0, 1'b1, 2};
      vecs[11] = '{32'h1234_5678, 16'h1235,   16'h7FFF,   16'h0000,   1'b0, 1'b1, 18};
      vecs[12] = '{32'd1000000,   16'hFED4,   16'hF2FB,   16'h0064,   1'b0, 1'b0, 18};
      vecs[13] = '{32'h4000_0000, 16'h8000,   16'h8000,   16'h0000,   1'b0, 1'b0, 18};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset quotient", quotient, 0);
      check("reset flags", {div_by_zero, overflow}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: result must hold while out_ready stays low
      start_op("bp", 32'hFFFF_FF9C, 16'd7);
      wait_valid(n);
      check("bp latency", n, 18);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d", c), {out_valid, in_ready, quotient, div_by_zero, overflow},
               {1'b1, 1'b0, 16'hFFF2, 1'b0, 1'b0});
`ifdef SIGNED_DIVIDER_REM_EN
         check($sformatf("bp hold%0d remainder", c), remainder, 16'hFFFE);
`endif
      end
      handshake();
      check("bp in_ready after handshake", in_ready, 1);
      check("bp out_valid after handshake", out_valid, 0);
      start_op("b2b", 32'd1234, 16'd0);
      wait_valid(n);
      check("b2b latency", n, 2);
      check_result("b2b", 16'h7FFF, 16'h04D2, 1'b1, 1'b0);
      handshake();

      // Reset while the iteration counter sits at 7
      start_op("rstmid", 32'd100, 16'd7);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      check("rstmid busy before reset", busy, 1);
      rst = 1'b1;
      #1;
      check("rstmid in_ready", in_ready, 1);
      check("rstmid out_valid", out_valid, 0);
      check("rstmid busy", busy, 0);
      check("rstmid flags", {div_by_zero, overflow}, 0);
      check("rstmid quotient", quotient, 0);
`ifdef SIGNED_DIVIDER_REM_EN
      check("rstmid remainder", remainder, 0);
`endif
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("after_rst", vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
